bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_rr2.sv | 26 ++
 rtl/bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the two-master read arbiter: the FSM state encoding,
// the master identifiers and the AXI read-response codes.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IFU = 2'd1,
    ST_GRANT_LSU = 2'd2
  } state_t;

  typedef enum logic {
    MID_IFU = 1'b0,
    MID_LSU = 1'b1
  } master_id_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin pick. A single requester always wins; on a tie the
// requester that was not granted last wins.
//   req[1:0] : request vector, bit 0 = IFU, bit 1 = LSU
//   last     : master granted most recently
//   grant    : one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module arb_rr2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last,
  output logic [1:0] grant
);

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == MID_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule : arb_rr2

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Arbitrates the AR/R read channels of an instruction fetch unit (IFU) and a
// load/store unit (LSU) onto one memory-side read port. Exactly one read is
// outstanding at a time; grants alternate on ties.
//
// Ports
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   ifu_ar* / ifu_r*       : IFU read address / read data channels
//   lsu_ar* / lsu_r*       : LSU read address / read data channels
//   s_ar* / s_r*           : memory-side read address / read data channels
//
// Optional build macro
//   CONFIG_ARB_BURST_EN    : adds arlen/arsize/arburst/rlast routing; the
//                            transaction then ends on the beat with rlast set.
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              ifu_rready,
  // LSU
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  input  logic              lsu_rready,
`ifdef CONFIG_ARB_BURST_EN
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rlast,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rlast,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rlast,
`endif
  // Memory side
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready
);

  state_t     r_state,      w_state_nxt;
  master_id_t r_last_grant, w_last_nxt;
  logic       r_ar_done,    w_ar_done_nxt;

  logic [1:0] w_grant;
  logic       w_busy;
  logic       w_own_lsu;
  logic       w_own_arvalid;
  logic       w_own_rready;
  logic       w_last_beat;
  logic       w_r_final;

  arb_rr2 u_rr (
    .req   ({lsu_arvalid, ifu_arvalid}),
    .last  (r_last_grant),
    .grant (w_grant)
  );

  assign w_busy        = (r_state != ST_IDLE);
  assign w_own_lsu     = (r_state == ST_GRANT_LSU);
  assign w_own_arvalid = w_own_lsu ? lsu_arvalid : ifu_arvalid;
  assign w_own_rready  = w_own_lsu ? lsu_rready  : ifu_rready;

`ifdef CONFIG_ARB_BURST_EN
  assign w_last_beat = s_rlast;
`else
  assign w_last_beat = 1'b1;
`endif

  // R beats only count once the address has been accepted; earlier or idle
  // s_rvalid pulses belong to nothing this arbiter issued.
  assign w_r_final = w_busy && r_ar_done && s_rvalid && w_own_rready && w_last_beat;

  // NOTE: reset is sampled on the clock edge (synchronous), and state
  // registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= MID_LSU;
      r_ar_done    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_ar_done    <= w_ar_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last_grant;
    w_ar_done_nxt = r_ar_done;
    case (r_state)
      ST_IDLE: begin
        w_ar_done_nxt = 1'b0;
        if (w_grant[0]) begin
          w_state_nxt = ST_GRANT_IFU;
          w_last_nxt  = MID_IFU;
        end else if (w_grant[1]) begin
          w_state_nxt = ST_GRANT_LSU;
          w_last_nxt  = MID_LSU;
        end
      end
      ST_GRANT_IFU, ST_GRANT_LSU: begin
        if (!r_ar_done) begin
          // Owner withdrew before the address was taken: nothing was issued.
          if (!w_own_arvalid) begin
            w_state_nxt = ST_IDLE;
          end else if (s_arready) begin
            w_ar_done_nxt = 1'b1;
          end
        end else if (w_r_final) begin
          w_state_nxt   = ST_IDLE;
          w_ar_done_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_ar_done_nxt = 1'b0;
      end
    endcase
  end

  // Channel routing. Read data and response fan out to both masters; only the
  // owner sees valid/ready, and the AR channel closes once the address is taken.
  always_comb begin
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_rready    = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_rdata   = s_rdata;
    lsu_rdata   = s_rdata;
    ifu_rresp   = s_rresp;
    lsu_rresp   = s_rresp;
`ifdef CONFIG_ARB_BURST_EN
    s_arlen     = '0;
    s_arsize    = '0;
    s_arburst   = '0;
    ifu_rlast   = 1'b0;
    lsu_rlast   = 1'b0;
`endif
    if (w_busy) begin
      s_arvalid = w_own_arvalid & ~r_ar_done;
      s_araddr  = w_own_lsu ? lsu_araddr : ifu_araddr;
      s_rready  = w_own_rready & r_ar_done;
`ifdef CONFIG_ARB_BURST_EN
      s_arlen   = w_own_lsu ? lsu_arlen   : ifu_arlen;
      s_arsize  = w_own_lsu ? lsu_arsize  : ifu_arsize;
      s_arburst = w_own_lsu ? lsu_arburst : ifu_arburst;
`endif
      if (w_own_lsu) begin
        lsu_arready = s_arready & ~r_ar_done;
        lsu_rvalid  = s_rvalid  &  r_ar_done;
`ifdef CONFIG_ARB_BURST_EN
        lsu_rlast   = s_rlast   &  r_ar_done;
`endif
      end else begin
        ifu_arready = s_arready & ~r_ar_done;
        ifu_rvalid  = s_rvalid  &  r_ar_done;
`ifdef CONFIG_ARB_BURST_EN
        ifu_rlast   = s_rlast   &  r_ar_done;
`endif
      end
    end
  end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter: a table of directed cycles, an optional
// burst sequence (CONFIG_ARB_BURST_EN) and a randomized phase scored against a
// transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] IFU_ADDR = 32'h8000_0000;
  localparam logic [AW-1:0] LSU_ADDR = 32'h1000_0000;
  localparam logic [DW-1:0] RDATA    = 32'h0000_0413;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [AW-1:0] ifu_araddr;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [AW-1:0] lsu_araddr;
  logic [DW-1:0] lsu_rdata;
  logic [1:0]    lsu_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
`ifdef CONFIG_ARB_BURST_EN
  logic [7:0] ifu_arlen, lsu_arlen, s_arlen;
  logic [2:0] ifu_arsize, lsu_arsize, s_arsize;
  logic [1:0] ifu_arburst, lsu_arburst, s_arburst;
  logic       ifu_rlast, lsu_rlast, s_rlast;
`endif

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .ifu_arvalid (ifu_arvalid),
    .ifu_araddr  (ifu_araddr),
    .ifu_arready (ifu_arready),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rready  (ifu_rready),
    .lsu_arvalid (lsu_arvalid),
    .lsu_araddr  (lsu_araddr),
    .lsu_arready (lsu_arready),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .lsu_rresp   (lsu_rresp),
    .lsu_rready  (lsu_rready),
`ifdef CONFIG_ARB_BURST_EN
    .ifu_arlen   (ifu_arlen),
    .ifu_arsize  (ifu_arsize),
    .ifu_arburst (ifu_arburst),
    .ifu_rlast   (ifu_rlast),
    .lsu_arlen   (lsu_arlen),
    .lsu_arsize  (lsu_arsize),
    .lsu_arburst (lsu_arburst),
    .lsu_rlast   (lsu_rlast),
    .s_arlen     (s_arlen),
    .s_arsize    (s_arsize),
    .s_arburst   (s_arburst),
    .s_rlast     (s_rlast),
`endif
    .s_arvalid   (s_arvalid),
    .s_araddr    (s_araddr),
    .s_arready   (s_arready),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rready    (s_rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output handshake bits in one word: {s_arvalid, ifu_arready, lsu_arready,
  // ifu_rvalid, lsu_rvalid, s_rready}.
  function automatic logic [5:0] out_vec();
    return {s_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, s_rready};
  endfunction

  task automatic drive_idle();
    reset = 1'b0;
    ifu_arvalid = 1'b0; ifu_araddr = IFU_ADDR; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = LSU_ADDR; lsu_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = RDATA; s_rresp = RESP_OKAY;
`ifdef CONFIG_ARB_BURST_EN
    ifu_arlen = '0; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
    lsu_arlen = '0; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
    s_rlast = 1'b1;
`endif
  endtask

  typedef struct {
    bit         rst, iav, lav, sar, srv, irr, lrr;
    logic [1:0] resp;
    logic [5:0] e_out;
    state_t     e_state;
  } vec_t;

  function automatic vec_t v(bit rst, bit iav, bit lav, bit sar, bit srv, bit irr,
                             bit lrr, logic [1:0] resp, logic [5:0] e, state_t st);
    vec_t r;
    r.rst = rst; r.iav = iav; r.lav = lav; r.sar = sar; r.srv = srv;
    r.irr = irr; r.lrr = lrr; r.resp = resp; r.e_out = e; r.e_state = st;
    return r;
  endfunction

  vec_t tbl[$];

  // Reference model state for the random phase (owner -1 = nobody).
  int m_owner;
  bit m_done;
  int m_last;

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Rows: rst iav lav sar srv irr lrr resp | {sav iar lar irv lrv srr} state
    // IFU alone reads 0x8000_0000, arready after 2 cycles, data after 3.
    tbl.push_back(v(0,1,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,1,0,0,0,0,0,RESP_OKAY,   6'b100000, ST_GRANT_IFU));
    tbl.push_back(v(0,1,0,1,0,0,0,RESP_OKAY,   6'b110000, ST_GRANT_IFU));
    tbl.push_back(v(0,0,0,0,1,1,0,RESP_OKAY,   6'b000101, ST_GRANT_IFU));
    tbl.push_back(v(0,0,0,0,1,1,1,RESP_OKAY,   6'b000000, ST_IDLE));      // stale rvalid
    // Tie right after reset: IFU first, LSU two cycles after IFU's R handshake.
    tbl.push_back(v(1,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,1,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,1,1,0,0,0,0,RESP_OKAY,   6'b100000, ST_GRANT_IFU));
    tbl.push_back(v(0,1,1,1,0,0,0,RESP_OKAY,   6'b110000, ST_GRANT_IFU));
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_GRANT_IFU));
    tbl.push_back(v(0,0,1,0,1,1,0,RESP_OKAY,   6'b000101, ST_GRANT_IFU));
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b100000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,1,1,0,0,0,RESP_OKAY,   6'b101000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,1,0,1,RESP_OKAY,   6'b000011, ST_GRANT_LSU));
    tbl.push_back(v(0,1,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,1,1,0,0,0,0,RESP_OKAY,   6'b100000, ST_GRANT_IFU)); // next tie -> IFU
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_GRANT_IFU));
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    // LSU raises arvalid then drops it before s_arready.
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b100000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    // SLVERR is forwarded and still releases the grant.
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,0,1,1,0,0,0,RESP_OKAY,   6'b101000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,1,0,1,RESP_SLVERR, 6'b000011, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    // Reset while GRANT_LSU waits for R; a later stale rvalid is ignored.
    tbl.push_back(v(0,0,1,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,0,1,1,0,0,0,RESP_OKAY,   6'b101000, ST_GRANT_LSU));
    tbl.push_back(v(1,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_GRANT_LSU));
    tbl.push_back(v(0,0,0,0,1,1,1,RESP_OKAY,   6'b000000, ST_IDLE));
    tbl.push_back(v(0,0,0,0,0,0,0,RESP_OKAY,   6'b000000, ST_IDLE));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock); #1;
      reset       = tbl[i].rst;
      ifu_arvalid = tbl[i].iav;
      lsu_arvalid = tbl[i].lav;
      s_arready   = tbl[i].sar;
      s_rvalid    = tbl[i].srv;
      ifu_rready  = tbl[i].irr;
      lsu_rready  = tbl[i].lrr;
      s_rresp     = tbl[i].resp;
      @(negedge clock);
      check($sformatf("row%0d handshakes", i), 64'(out_vec()), 64'(tbl[i].e_out));
      check($sformatf("row%0d state", i), 64'(dut.r_state), 64'(tbl[i].e_state));
      check($sformatf("row%0d rdata", i), {ifu_rdata, lsu_rdata}, {RDATA, RDATA});
      check($sformatf("row%0d rresp", i), 64'({ifu_rresp, lsu_rresp}),
            64'({tbl[i].resp, tbl[i].resp}));
      if (tbl[i].e_out[5])
        check($sformatf("row%0d araddr", i), 64'(s_araddr),
              64'((tbl[i].e_state == ST_GRANT_LSU) ? LSU_ADDR : IFU_ADDR));
    end

`ifdef CONFIG_ARB_BURST_EN
    // IFU burst of 4 beats while LSU waits; LSU granted only after the last beat.
    begin
      int beats;
      beats = 0;
      @(posedge clock); #1; drive_idle(); reset = 1'b1;
      @(posedge clock); #1; reset = 1'b0;
      ifu_arvalid = 1'b1; ifu_arlen = 8'd3; lsu_arvalid = 1'b1; lsu_arlen = 8'd7;
      @(negedge clock);
      check("burst idle", 64'(dut.r_state), 64'(ST_IDLE));
      @(posedge clock); #1;
      @(negedge clock);
      check("burst grant ifu", 64'(dut.r_state), 64'(ST_GRANT_IFU));
      check("burst arlen", 64'(s_arlen), 64'd3);
      @(posedge clock); #1; s_arready = 1'b1;
      @(negedge clock);
      check("burst ar hs", 64'({s_arvalid, ifu_arready}), 64'(2'b11));
      @(posedge clock); #1;
      ifu_arvalid = 1'b0; s_arready = 1'b0; ifu_rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
        s_rvalid = 1'b1; s_rlast = (b == 3);
        @(negedge clock);
        if (ifu_rvalid && s_rready) beats++;
        check($sformatf("burst beat%0d", b), 64'({ifu_rvalid, ifu_rlast, lsu_rvalid, lsu_arready}),
              64'({1'b1, (b == 3), 1'b0, 1'b0}));
        check($sformatf("burst beat%0d state", b), 64'(dut.r_state), 64'(ST_GRANT_IFU));
        @(posedge clock); #1;
      end
      s_rvalid = 1'b0; s_rlast = 1'b1; ifu_rready = 1'b0;
      check("burst beat count", 64'(beats), 64'd4);
      @(negedge clock);
      check("burst release", 64'(dut.r_state), 64'(ST_IDLE));
      @(posedge clock); #1;
      @(negedge clock);
      check("burst lsu after", 64'(dut.r_state), 64'(ST_GRANT_LSU));
      check("burst lsu arlen", 64'(s_arlen), 64'd7);
    end
`endif

    // Randomized phase against a transaction-level model.
    @(posedge clock); #1; drive_idle(); reset = 1'b1;
    m_owner = -1; m_done = 1'b0; m_last = 1;
    for (int c = 0; c < 3000; c++) begin
      bit [1:0]     av, rr;
      logic [AW-1:0] ad [2];
      logic [5:0]   e;
      logic [AW-1:0] e_addr;
`ifdef CONFIG_ARB_BURST_EN
      logic [7:0]   ln [2];
      logic [7:0]   e_len;
`endif
      bit           lastb;
      @(posedge clock); #1;
      reset       = ($urandom_range(0, 99) == 0);
      av          = 2'($urandom);
      rr          = 2'($urandom);
      ifu_arvalid = av[0]; lsu_arvalid = av[1];
      ifu_rready  = rr[0]; lsu_rready  = rr[1];
      ifu_araddr  = $urandom; lsu_araddr = $urandom;
      ad[0] = ifu_araddr; ad[1] = lsu_araddr;
      s_arready   = $urandom_range(0, 1);
      s_rvalid    = $urandom_range(0, 1);
      s_rdata     = $urandom;
      s_rresp     = 2'($urandom);
      lastb       = 1'b1;
`ifdef CONFIG_ARB_BURST_EN
      ifu_arlen = 8'($urandom); lsu_arlen = 8'($urandom);
      ln[0] = ifu_arlen; ln[1] = lsu_arlen;
      s_rlast = $urandom_range(0, 1);
      lastb   = s_rlast;
`endif
      @(negedge clock);
      // Expected outputs from the current owner and whether its address was taken.
      e = '0; e_addr = '0;
      if (m_owner >= 0) begin
        e[5] = av[m_owner] && !m_done;
        e[4 - m_owner] = s_arready && !m_done;
        e[2 - m_owner] = s_rvalid && m_done;
        e[0] = rr[m_owner] && m_done;
        e_addr = ad[m_owner];
      end
      check($sformatf("rand%0d handshakes", c), 64'(out_vec()), 64'(e));
      check($sformatf("rand%0d araddr", c), 64'(s_araddr), 64'(e_addr));
      check($sformatf("rand%0d bcast", c), {ifu_rdata, lsu_rdata}, {s_rdata, s_rdata});
`ifdef CONFIG_ARB_BURST_EN
      e_len = (m_owner >= 0) ? ln[m_owner] : 8'd0;
      check($sformatf("rand%0d arlen", c), 64'(s_arlen), 64'(e_len));
      check($sformatf("rand%0d rlast", c), 64'({ifu_rlast, lsu_rlast}),
            64'({(m_owner == 0) && m_done && s_rlast, (m_owner == 1) && m_done && s_rlast}));
`endif
      // Advance the model by one clock.
      if (reset) begin
        m_owner = -1; m_done = 1'b0; m_last = 1;
      end else if (m_owner < 0) begin
        if (av == 2'b11) m_owner = 1 - m_last;
        else if (av[0])  m_owner = 0;
        else if (av[1])  m_owner = 1;
        if (m_owner >= 0) m_last = m_owner;
        m_done = 1'b0;
      end else if (!m_done) begin
        if (!av[m_owner]) m_owner = -1;
        else if (s_arready) m_done = 1'b1;
      end else if (s_rvalid && rr[m_owner] && lastb) begin
        m_owner = -1; m_done = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bus_arbiter
